// File: rtl/st_sample_packer.sv
// st_sample_packer
// Packs a stream of 16-bit samples into 32-bit Avalon-ST words, two samples
// per word with the earlier sample in the upper half. Samples are grouped
// into packets of PKT_SAMPLES; an odd-length packet ends with a half-filled
// word flagged with out_empty = 2.
module st_sample_packer #(
  parameter int PKT_SAMPLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty
);

  // Index of the final sample in a packet; the index counter is 16 bits
  // wide so it covers the full legal PKT_SAMPLES range.
  localparam logic [15:0] LAST_IDX = 16'(PKT_SAMPLES - 1);

  // EMPTY: no sample waiting for a partner; HALF: one sample held.
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] idx;
  logic [15:0] hold;

  logic        half;
  logic        last_sample;
  logic        accept;
  logic        load;

  logic [31:0] next_data;
  logic [1:0]  next_empty;
  logic        next_eop;
  logic        next_sop;

  assign half        = (state == HALF);
  assign last_sample = (idx == LAST_IDX);

  // A sample can be taken whenever it will not produce a word, or the
  // output register is free / being drained this cycle.
  assign in_ready = ~out_valid | out_ready | (~half & ~last_sample);
  assign accept   = in_valid & in_ready;
  assign load     = accept & (half | last_sample);

  // Build the word that would be loaded if the current sample is accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_data  = {in_data, 16'h0000};
    next_empty = 2'd2;
    next_eop   = 1'b1;
    next_sop   = (idx == 16'd0);
    if (half) begin
      next_data  = {hold, in_data};
      next_empty = 2'd0;
      next_eop   = last_sample;
      // The held sample sits one index behind the current one, so the word
      // starts the packet exactly when the current sample is index 1.
      next_sop   = (idx == 16'd1);
    end
  end

  // Input side: sample index, pairing state and holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the clock edge.
      state <= EMPTY;
      idx   <= 16'd0;
      hold  <= 16'h0000;
    end else if (accept) begin
      idx <= last_sample ? 16'd0 : idx + 16'd1;
      if (half) begin
        state <= EMPTY;
      end else if (!last_sample) begin
        state <= HALF;
        hold  <= in_data;
      end
    end
  end

  // Output register: load replaces the word (even while draining), a drain
  // with no load empties it, otherwise the word is held stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= 32'h0000_0000;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= 2'd0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_data          <= next_data;
      out_startofpacket <= next_sop;
      out_endofpacket   <= next_eop;
      out_empty         <= next_empty;
    end else if (out_valid && out_ready) begin
      // Payload is left in place after a drain; only valid qualifies it.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_st_sample_packer.sv
// Testbench for st_sample_packer. Four instances with PKT_SAMPLES of 4, 3,
// 1 and 256 share one clock and reset. Stimulus pushes expected words into
// per-instance queues; a monitor pops and compares on every output transfer.
module tb_st_sample_packer;

  localparam int NDUT = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } word_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid  [NDUT];
  logic [15:0] in_data   [NDUT];
  logic        in_ready  [NDUT];
  logic        out_valid [NDUT];
  logic [31:0] out_data  [NDUT];
  logic        out_ready [NDUT];
  logic        out_sop   [NDUT];
  logic        out_eop   [NDUT];
  logic [1:0]  out_empty [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: position within packet and unpaired sample.
  word_t       exp_q [NDUT][$];
  int          pos   [NDUT];
  logic [15:0] pend  [NDUT];
  int          nrx   [NDUT];

  function automatic int pkt_len(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      2:       return 1;
      default: return 256;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    st_sample_packer #(
      .PKT_SAMPLES((g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 1 : 256)
    ) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .in_valid         (in_valid[g]),
      .in_data          (in_data[g]),
      .in_ready         (in_ready[g]),
      .out_valid        (out_valid[g]),
      .out_data         (out_data[g]),
      .out_ready        (out_ready[g]),
      .out_startofpacket(out_sop[g]),
      .out_endofpacket  (out_eop[g]),
      .out_empty        (out_empty[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: sample at packet position p belongs to word p/2; the
  // word is complete when its second sample arrives or the packet ends.
  task automatic model_accept(input int k, input logic [15:0] d);
    word_t w;
    int    p;
    int    n;
    p = pos[k];
    n = pkt_len(k);
    if (p % 2 == 0) begin
      if (p == n - 1) begin
        w = '{data: {d, 16'h0000}, sop: (p == 0), eop: 1'b1, empty: 2'd2};
        exp_q[k].push_back(w);
      end else begin
        pend[k] = d;
      end
    end else begin
      w = '{data: {pend[k], d}, sop: (p == 1), eop: (p == n - 1), empty: 2'd0};
      exp_q[k].push_back(w);
    end
    pos[k] = (p + 1) % n;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      exp_q[k].delete();
      pos[k]  = 0;
      pend[k] = 16'h0000;
    end
  endtask

  // Monitor: runs between edges after stimulus has settled; a word is
  // transferred at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < NDUT; k++) begin
      if (reset_n && out_valid[k] && out_ready[k]) begin
        word_t act;
        word_t exp;
        act = '{data: out_data[k], sop: out_sop[k], eop: out_eop[k], empty: out_empty[k]};
        n_cmp++;
        nrx[k]++;
        if (exp_q[k].size() == 0) begin
          n_err++;
          $display("FAIL word_unexpected dut%0d: got data=0x%08h sop=%0b eop=%0b empty=%0d, expected no word",
                   k, act.data, act.sop, act.eop, act.empty);
        end else begin
          exp = exp_q[k].pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL word dut%0d: got data=0x%08h sop=%0b eop=%0b empty=%0d, expected data=0x%08h sop=%0b eop=%0b empty=%0d",
                     k, act.data, act.sop, act.eop, act.empty, exp.data, exp.sop, exp.eop, exp.empty);
          end
        end
      end
    end
  end

  // One clock of stimulus on instance k, starting at a falling edge.
  task automatic cycle(input int k, input logic v, input logic [15:0] d, input logic r, output logic acc);
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = r;
    #1;
    acc = v & in_ready[k];
    if (acc) model_accept(k, d);
    @(negedge clk);
  endtask

  // Offer one sample until accepted, bounded.
  task automatic send(input int k, input logic [15:0] d, input logic r);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cycle(k, 1'b1, d, r, acc);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout dut%0d: got no accept, expected accept of 0x%04h", k, d);
    end
  endtask

  task automatic idle(input int k, input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(k, 1'b0, 16'h0000, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   cyc;

    reset_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 16'h0000;
      out_ready[k] = 1'b1;
      nrx[k]       = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state on every instance.
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_valid%0d", k), {31'd0, out_valid[k]}, 32'd0);
      check($sformatf("rst_data%0d", k), out_data[k], 32'd0);
      check($sformatf("rst_flags%0d", k), {29'd0, out_sop[k], out_eop[k], out_empty[k]}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready[0]}, 32'd1);

    // PKT_SAMPLES=4 back-to-back, with one-cycle latency and full throughput.
    cycle(0, 1'b1, 16'h0001, 1'b1, acc);
    check("tput_s1", {31'd0, acc}, 32'd1);
    cycle(0, 1'b1, 16'h0002, 1'b1, acc);
    check("tput_s2", {31'd0, acc}, 32'd1);
    check("latency_valid", {31'd0, out_valid[0]}, 32'd1);
    check("latency_data", out_data[0], 32'h0001_0002);
    cycle(0, 1'b1, 16'h0003, 1'b1, acc);
    check("tput_s3", {31'd0, acc}, 32'd1);
    cycle(0, 1'b1, 16'h0004, 1'b1, acc);
    check("tput_s4", {31'd0, acc}, 32'd1);
    idle(0, 3);

    // PKT_SAMPLES=3: odd packets end with a half word.
    for (int i = 0; i < 6; i++) send(1, 16'(16'h000A + i), 1'b1);
    idle(1, 3);

    // PKT_SAMPLES=1: every word is a single-sample packet.
    send(2, 16'h1234, 1'b1);
    send(2, 16'h5678, 1'b1);
    idle(2, 3);

    // Backpressure: third sample still taken, fourth refused while stalled.
    send(0, 16'h0001, 1'b1);
    send(0, 16'h0002, 1'b1);
    cycle(0, 1'b1, 16'h0003, 1'b0, acc);
    check("stall_accept_empty", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, 16'h0004, 1'b0, acc);
      check("stall_refuse_half", {31'd0, acc}, 32'd0);
      check("stall_hold_data", out_data[0], 32'h0001_0002);
      check("stall_hold_flags", {29'd0, out_valid[0], out_sop[0], out_eop[0]}, 32'd6);
    end
    cycle(0, 1'b1, 16'h0004, 1'b1, acc);
    check("stall_release_accept", {31'd0, acc}, 32'd1);
    idle(0, 3);

    // Reset in the middle of a packet with a stalled word present.
    send(0, 16'h0001, 1'b1);
    send(0, 16'h0002, 1'b1);
    send(0, 16'h0003, 1'b0);
    check("pre_reset_valid", {31'd0, out_valid[0]}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid[0]}, 32'd0);
    check("midrst_data", out_data[0], 32'd0);
    check("midrst_flags", {29'd0, out_sop[0], out_eop[0], out_empty[0]}, 32'd0);
    model_reset();
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, in_ready[0]}, 32'd1);
    for (int i = 0; i < 4; i++) send(0, 16'(16'h0005 + i), 1'b1);
    idle(0, 3);

    // Random traffic on PKT_SAMPLES=256.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      cycle(3, ($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) < 6), acc);
      if (acc) sent++;
      cyc++;
    end
    check("rand_samples_sent", sent, 32'd10000);
    idle(3, 5);

    check("rand_words_rx", nrx[3], 32'd5000);
    for (int k = 0; k < NDUT; k++)
      check($sformatf("queue_drained%0d", k), exp_q[k].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/st_sample_packer.md
ST_SAMPLE_PACKER -- requirements
Module: st_sample_packer

Interface
REQ-001 SHALL provide parameter PKT_SAMPLES, default 256, number of 16-bit samples per output packet; legal range 1..65535.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid  input  1  upstream sample valid.
REQ-005 SHALL provide port in_data  input  16  upstream sample.
REQ-006 SHALL provide port in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-007 SHALL provide port out_valid  output  1  Avalon-ST source valid, registered.
REQ-008 SHALL provide port out_data  output  32  packed word, registered.
REQ-009 SHALL provide port out_ready  input  1  sink ready, ready latency 0.
REQ-010 SHALL provide ports out_startofpacket, out_endofpacket  output  1 each  packet framing, registered.
REQ-011 SHALL provide port out_empty  output  2  empty byte count on EOP word, registered.

Function
REQ-012 SHALL keep a sample index counter 0..PKT_SAMPLES-1, incremented per accepted sample, wrapping to 0 after PKT_SAMPLES-1.
REQ-013 SHALL keep a 16-bit holding register and half flag; states EMPTY (half=0) and HALF (half=1).
REQ-014 EMPTY, accepted sample not last in packet -> store in holding register, go HALF, no output word.
REQ-015 EMPTY, accepted sample last in packet (odd PKT_SAMPLES) -> load output word {sample,16'h0000}, out_empty=2, EOP=1, stay EMPTY.
REQ-016 HALF, accepted sample -> load output word {held,sample}, out_empty=0, EOP=1 iff sample is last in packet, go EMPTY.
REQ-017 SHALL place earlier sample in out_data[31:16] (first-symbol-in-MSBs ordering).
REQ-018 SHALL assert out_startofpacket on the word containing sample index 0; deassert otherwise.
REQ-019 SHALL assert out_empty nonzero only with out_endofpacket; non-EOP words have out_empty=0.
REQ-020 Output register: out_valid set when a word loads; cleared when out_valid & out_ready and no new word loads same cycle; load with simultaneous drain SHALL replace word without bubble.
REQ-021 in_ready SHALL equal (~out_valid | out_ready | (~half & ~last_sample)), combinational; last_sample = (index == PKT_SAMPLES-1).
REQ-022 Output word and flags SHALL hold stable while out_valid & ~out_ready.
REQ-023 Latency: word visible on out_valid the cycle after its second (or sole) sample is accepted.
REQ-024 PKT_SAMPLES=1 -> every word has SOP=EOP=1, out_empty=2, half never set.
REQ-025 Sustained throughput SHALL be one sample per cycle with out_ready held high.
REQ-026 in_data SHALL be ignored when in_valid=0 or in_ready=0; no state change.

Reset
REQ-027 On reset_n low SHALL immediately clear out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, holding register, half flag and index counter to 0.
REQ-028 After reset release, in_ready SHALL be 1 and first accepted sample SHALL be index 0.
REQ-029 Reset mid-packet SHALL discard held sample and partial packet; no word emitted for it.

Verification
REQ-030 PKT_SAMPLES=4, out_ready=1, samples 0x0001..0x0004 back-to-back -> words 0x00010002 (SOP, empty 0), 0x00030004 (EOP, empty 0).
REQ-031 PKT_SAMPLES=3, samples 0xA,0xB,0xC,0xD,0xE,0xF -> 0x000A000B SOP; 0x000C0000 EOP empty 2; 0x000D000E SOP; 0x000F0000 EOP empty 2.
REQ-032 PKT_SAMPLES=4, out_ready=0 after first word loads -> in_ready stays 1 for third sample, drops with HALF state, word held stable until out_ready=1.
REQ-033 PKT_SAMPLES=1, samples 0x1234,0x5678 -> 0x12340000 and 0x56780000, each SOP=EOP=1, empty 2.
REQ-034 PKT_SAMPLES=4, reset_n pulsed low after 3 samples accepted -> outputs 0 immediately; next samples 0x0005..0x0008 -> 0x00050006 with SOP.
REQ-035 Random in_valid/out_ready, PKT_SAMPLES=256, 10000 samples -> scoreboard match, no loss/duplication, SOP/EOP every 128 words.
